// File: rtl/multicycle_control_if.sv
//------------------------------------------------------------------------------
// Module  : multicycle_control_if
// Purpose : Bundles the instruction/datapath/memory handshake signals between
//           the multicycle controller and its surroundings.
// Ports   : opcode, alu_zero, imem_ready, dmem_ready      (into controller)
//           imem_req, dmem_req, ir_write, pc_write, pc_src,
//           reg2loc, alusrc, mem2reg, regwrite, memread, memwrite,
//           aluop, signop, illegal, timeout, instret      (out of controller)
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_if #(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
);
    logic [10:0]        opcode;
    logic               alu_zero;
    logic               imem_ready;
    logic               dmem_ready;
    logic               imem_req;
    logic               dmem_req;
    logic               ir_write;
    logic               pc_write;
    logic               pc_src;
    logic               reg2loc;
    logic               alusrc;
    logic               mem2reg;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic [ALUOP_W-1:0] aluop;
    logic [2:0]         signop;
    logic               illegal;
    logic               timeout;
    logic [CNT_W-1:0]   instret;

    // Datapath / memory side
    modport master (
        output opcode, alu_zero, imem_ready, dmem_ready,
        input  imem_req, dmem_req, ir_write, pc_write, pc_src,
               reg2loc, alusrc, mem2reg, regwrite, memread, memwrite,
               aluop, signop, illegal, timeout, instret
    );

    // Controller side
    modport slave (
        input  opcode, alu_zero, imem_ready, dmem_ready,
        output imem_req, dmem_req, ir_write, pc_write, pc_src,
               reg2loc, alusrc, mem2reg, regwrite, memread, memwrite,
               aluop, signop, illegal, timeout, instret
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// Module  : multicycle_control
// Purpose : FETCH/DECODE/EXEC/MEM/WB/HALT control unit for a small ARMv8-like
//           multicycle datapath, with memory-wait timeout, sticky error flags
//           and a retired-instruction counter.
// Ports   : CLK    - clock, rising edge
//           resetl - asynchronous active-low reset
//           bus    - multicycle_control_if.slave (opcode, readies, strobes,
//                    decoded controls, illegal/timeout flags, instret)
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control #(
    parameter int ALUOP_W     = 4,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  wire logic             CLK,
    input  wire logic             resetl,
    multicycle_control_if.slave   bus
);

    // Wait counter runs 0 .. MEM_TIMEOUT-1 while a request is outstanding.
    localparam int              WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        K_ALU = 3'd0,
        K_B   = 3'd1,
        K_CBZ = 3'd2,
        K_LD  = 3'd3,
        K_ST  = 3'd4
    } kind_t;

    state_t            state_q, state_d;
    logic              started_q;       // low for the first cycle out of reset
    logic [WAIT_W-1:0] wait_q, wait_d;
    kind_t             kind_q;
    logic [3:0]        aluop_q;
    logic [2:0]        signop_q;
    logic              reg2loc_q, alusrc_q, mem2reg_q;
    logic              illegal_q, timeout_q;
    logic [CNT_W-1:0]  instret_q;

    // Opcode decode (first match wins)
    logic       dec_valid;
    kind_t      dec_kind;
    logic [3:0] dec_aluop;
    logic [2:0] dec_signop;
    logic       dec_r2l, dec_asrc, dec_m2r;

    always_comb begin
        dec_valid  = 1'b1;
        dec_kind   = K_ALU;
        dec_aluop  = 4'b0000;
        dec_signop = 3'b000;
        dec_r2l    = 1'b0;
        dec_asrc   = 1'b0;
        dec_m2r    = 1'b0;
        priority casez (bus.opcode)
            11'b?0001010???: dec_aluop = 4'b0000;                       // AND
            11'b?0101010???: dec_aluop = 4'b0001;                       // ORR
            11'b?0?01011???: dec_aluop = 4'b0010;                       // ADD
            11'b?1?01011???: dec_aluop = 4'b0110;                       // SUB
            11'b?0?10001???: begin dec_aluop = 4'b0010; dec_asrc = 1'b1; end // ADDI
            11'b?1?10001???: begin dec_aluop = 4'b0110; dec_asrc = 1'b1; end // SUBI
            11'b110100101??: begin                                      // MOVZ
                dec_aluop = 4'b0111; dec_signop = 3'b100; dec_asrc = 1'b1;
            end
            11'b?00101?????: begin dec_kind = K_B; dec_signop = 3'b010; end  // B
            11'b?011010????: begin                                      // CBZ
                dec_kind = K_CBZ; dec_aluop = 4'b0111; dec_signop = 3'b011; dec_r2l = 1'b1;
            end
            11'b??111000010: begin                                      // LDUR
                dec_kind = K_LD; dec_aluop = 4'b0010; dec_signop = 3'b001;
                dec_asrc = 1'b1; dec_m2r = 1'b1;
            end
            11'b??111000000: begin                                      // STUR
                dec_kind = K_ST; dec_aluop = 4'b0010; dec_signop = 3'b001;
                dec_asrc = 1'b1; dec_r2l = 1'b1;
            end
            default: dec_valid = 1'b0;
        endcase
    end

    // Next-state and strobes
    logic imem_req, dmem_req, ir_write, pc_write, pc_src;
    logic regwrite, memread, memwrite;
    logic ld_ctrl, set_illegal, set_timeout;
    logic wait_expired;

    assign wait_expired = (wait_q == WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        regwrite    = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        ld_ctrl     = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (started_q) begin
                    imem_req = 1'b1;
                    wait_d   = wait_q + WAIT_W'(1);
                    if (bus.imem_ready) begin
                        ir_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (wait_expired) begin
                        set_timeout = 1'b1;
                        state_d     = S_HALT;
                    end
                end
            end
            S_DECODE: begin
                if (dec_valid) begin
                    ld_ctrl = 1'b1;
                    state_d = S_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_EXEC: begin
                case (kind_q)
                    K_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    K_CBZ: begin
                        pc_write = 1'b1;
                        pc_src   = bus.alu_zero;
                        state_d  = S_FETCH;
                    end
                    K_LD, K_ST: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                memread  = (kind_q == K_LD);
                memwrite = (kind_q == K_ST);
                wait_d   = wait_q + WAIT_W'(1);
                if (bus.dmem_ready) begin
                    if (kind_q == K_LD) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (wait_expired) begin
                    set_timeout = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            default: ;  // S_HALT: wait for reset
        endcase
        // Every state change restarts the wait count (covers FETCH and MEM entry).
        if (state_d != state_q) begin
            wait_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q   <= S_FETCH;
            started_q <= 1'b0;
            wait_q    <= '0;
            kind_q    <= K_ALU;
            aluop_q   <= 4'b0000;
            signop_q  <= 3'b000;
            reg2loc_q <= 1'b0;
            alusrc_q  <= 1'b0;
            mem2reg_q <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            wait_q    <= wait_d;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_timeout) timeout_q <= 1'b1;
            if (pc_write)    instret_q <= instret_q + CNT_W'(1);
            // Decoded controls live from DECODE exit until the next FETCH entry.
            if (state_d == S_FETCH && state_q != S_FETCH) begin
                kind_q    <= K_ALU;
                aluop_q   <= 4'b0000;
                signop_q  <= 3'b000;
                reg2loc_q <= 1'b0;
                alusrc_q  <= 1'b0;
                mem2reg_q <= 1'b0;
            end else if (ld_ctrl) begin
                kind_q    <= dec_kind;
                aluop_q   <= dec_aluop;
                signop_q  <= dec_signop;
                reg2loc_q <= dec_r2l;
                alusrc_q  <= dec_asrc;
                mem2reg_q <= dec_m2r;
            end
        end
    end

    assign bus.imem_req = imem_req;
    assign bus.dmem_req = dmem_req;
    assign bus.ir_write = ir_write;
    assign bus.pc_write = pc_write;
    assign bus.pc_src   = pc_src;
    assign bus.regwrite = regwrite;
    assign bus.memread  = memread;
    assign bus.memwrite = memwrite;
    assign bus.reg2loc  = reg2loc_q;
    assign bus.alusrc   = alusrc_q;
    assign bus.mem2reg  = mem2reg_q;
    assign bus.aluop    = ALUOP_W'(aluop_q);
    assign bus.signop   = signop_q;
    assign bus.illegal  = illegal_q;
    assign bus.timeout  = timeout_q;
    assign bus.instret  = instret_q;

endmodule

`default_nettype wire
